elastic_pipe_stage: RTL

Parametrised, flow-controlled pipeline stage register that replaces fixed always-advancing stage registers wherever a stage can stall (e.g. IF/ID behind a multi-cycle memory, EX/MEM behind a multi-cycle divider). It holds up to DEPTH payload words in a small ring buffer with a valid/ready handshake on both sides and a synchronous flush. The payload is zeroed when empty, so downstream sees a NOP bubble exactly as with the existing stage registers.

---
 rtl/elastic_pipe_stage_pkg.sv | 18 +
 rtl/elastic_pipe_ptr.sv | 40 ++++
 rtl/elastic_pipe_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/elastic_pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage_pkg
//   Shared definitions for the elastic pipeline stage register.
//   - WORD_LEN  : default payload width, the machine word length.
//   - stageOp_e : per-cycle buffer operation, encoded as {push, pop}.
// -----------------------------------------------------------------------------
package elastic_pipe_stage_pkg;

    localparam int WORD_LEN = 32;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } stageOp_e;

endpackage

// File: rtl/elastic_pipe_ptr.sv
// -----------------------------------------------------------------------------
// elastic_pipe_ptr
//   Mod-DEPTH wrapping pointer used for the head and tail of the stage buffer.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-low reset, pointer -> 0
//     clear  in   synchronous clear, pointer -> 0 (wins over incr)
//     incr   in   advance pointer by one, wrapping DEPTH-1 -> 0
//     ptr    out  current pointer value
// -----------------------------------------------------------------------------
module elastic_pipe_ptr
    import elastic_pipe_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    // A one-entry buffer still needs a 1-bit pointer so the port has a width.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          incr,
    output logic [PW-1:0] ptr
);

    // Wrap is an explicit compare so non-power-of-2 depths stay in range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (incr) begin
            if (ptr == PW'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage
//   Flow-controlled pipeline stage register: a DEPTH-entry ring buffer with a
//   valid/ready handshake on both sides and a synchronous flush. outData is
//   forced to zero when empty so downstream sees a NOP bubble.
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   asynchronous active-low reset
//     flush     in   synchronous flush, discards all held words
//     inValid   in   upstream offers inData
//     inReady   out  stage can accept a word (registered state only)
//     inData    in   upstream payload, WIDTH bits
//     outValid  out  outData holds a valid word
//     outReady  in   downstream consumes outData
//     outData   out  head entry, zero when outValid=0
//     count     out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module elastic_pipe_stage
    import elastic_pipe_stage_pkg::*;
#(
    parameter int WIDTH = WORD_LEN,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           inValid,
    output logic                           inReady,
    input  logic [WIDTH-1:0]               inData,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [WIDTH-1:0]               outData,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Sized to the full pointer range so every pointer value indexes a real
    // entry; slots at or above DEPTH are simply never addressed.
    localparam int NSLOT = 1 << PW;

    logic [WIDTH-1:0] storage [NSLOT];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic             push;
    logic             pop;
    stageOp_e         op;

    // Ready/valid come from occupancy only; no combinational path from
    // outReady to inReady.
    assign inReady  = (count != CW'(DEPTH));
    assign outValid = (count != '0);

    // Flush suppresses both handshakes in its cycle.
    assign push = inValid & inReady & ~flush;
    assign pop  = outValid & outReady & ~flush;
    assign op   = stageOp_e'({push, pop});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is not reset; the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wrPtr] <= inData;
        end
    end

    assign outData = outValid ? storage[rdPtr] : '0;

    elastic_pipe_ptr #(.DEPTH(DEPTH)) uRdPtr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .incr  (pop),
        .ptr   (rdPtr)
    );

    elastic_pipe_ptr #(.DEPTH(DEPTH)) uWrPtr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .incr  (push),
        .ptr   (wrPtr)
    );

endmodule
